pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-field, always-enabled inter-stage registers between EX/MEM and MEM/WB. It carries a generic control vector and data vector with a valid/ready handshake, a two-entry skid buffer for full throughput under back-pressure, and flush/bubble insertion. The control vector is forced to zero whenever the stage holds no valid entry, so downstream write enables never fire on a bubble. A saturating counter reports how many entries flushes have killed.

## Interface
Parameters:
- CTRL_W, 8, width of control vector (reg_write, mem_read, mem_write, dmem_to_reg, pc_select, ...); zeroed on bubble
- DATA_W, 133, width of data vector (alu result, store data, pc values, write address, offset); held, never zeroed
- CNT_W, 8, width of flush drop counter

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous kill of all held and incoming entries
- up_valid_i  in  1  upstream entry valid
- up_ready_o  out  1  stage can accept; registered
- up_ctrl_i  in  CTRL_W  upstream control vector
- up_data_i  in  DATA_W  upstream data vector
- dn_valid_o  out  1  downstream entry valid
- dn_ready_i  in  1  downstream accepts (stall = 0)
- dn_ctrl_o  out  CTRL_W  control out; all-zero when dn_valid_o = 0
- dn_data_o  out  DATA_W  data out
- occupancy_o  out  2  entries held (0, 1, 2)
- drop_count_o  out  CNT_W  entries killed by flush, saturating

## Operation
- Storage: main entry M drives dn_*; skid entry S holds overflow. up_ready_o = !S.valid.
- Accept = up_valid_i & up_ready_o. Deliver = dn_valid_o & dn_ready_i.
- States, with occupancy_o = 0/1/2:
  - EMPTY: accept -> ONE (M <= input).
  - ONE: accept & deliver -> ONE (M <= input); accept & !deliver -> FULL (S <= input); !accept & deliver -> EMPTY; else hold.
  - FULL: up_ready_o = 0. Deliver -> ONE (M <= S, S cleared); else hold.
- Ordering is strict FIFO. S never bypasses M.
- dn_ctrl_o = M.ctrl when M.valid, else 0. dn_data_o = M.data and retains its last value when invalid.
- Flush:
  - Next state is EMPTY. Both valid bits are cleared and S.ctrl/M.ctrl are zeroed.
  - Any accept in the same cycle is discarded.
  - A deliver in the flush cycle still counts as delivered to downstream.
- drop_count_o increments by (M.valid & !deliver) + S.valid + accept during flush. It saturates at 2^CNT_W-1 and never wraps.
- Priority: reset_ni > flush_i > normal handshake.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - dn_valid_o = 0, dn_ctrl_o = 0, dn_data_o = 0, occupancy_o = 0, drop_count_o = 0.
  - up_ready_o = 1, both during and after reset.
- Latency: an entry accepted at edge N appears on dn_* after edge N (visible in cycle N+1) when the stage was EMPTY, or ONE with deliver.
- Throughput is one entry per cycle with dn_ready_i held high.
- Back-pressure: when dn_ready_i drops, up_ready_o falls one cycle later, at most one extra entry is absorbed into S, and no entry is lost or duplicated.
- Ready path: up_ready_o is a flop output with no combinational path from dn_ready_i.
- Flush in the FULL state: outputs are invalid after the edge, up_ready_o = 1 next cycle, and drop_count_o increases by 2 (by 1 if deliver occurred that cycle).
- Reset mid-transfer: all held entries are lost with no count, and outputs go to reset values immediately without waiting for clk_i.
- Upstream inputs may change arbitrarily while up_valid_i = 0 or up_ready_o = 0. They are sampled only on accept.

## Test plan
- Streaming: up_valid_i = 1 and dn_ready_i = 1 for 10 cycles with data 1..10 -> dn_data_o shows 1..10 on consecutive cycles starting 1 cycle later, occupancy_o stays 1, up_ready_o stays 1.
- Stall: dn_ready_i low for 3 cycles mid-stream (ctrl = 8'hA5) -> up_ready_o low from 2nd stall cycle, occupancy_o = 2, order preserved, no gaps after release, dn_ctrl_o = 8'hA5 per entry.
- Bubble: up_valid_i = 0 with ctrl = 8'hFF on the input -> dn_valid_o = 0 and dn_ctrl_o = 8'h00; dn_data_o keeps the previous value.
- Flush in FULL with dn_ready_i = 0 and up_valid_i = 1 -> next cycle dn_valid_o = 0, occupancy_o = 0, drop_count_o += 2, and the input entry is not delivered.
- Saturation with CNT_W = 2: 5 flushes, each killing 1 entry -> drop_count_o reads 1, 2, 3, 3, 3.
- Async reset asserted between edges while FULL -> dn_valid_o = 0 and up_ready_o = 1 immediately; first post-reset accept emerges with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a valid/ready pipeline stage that holds up to two entries.
// The main entry (M) drives the downstream outputs and the skid entry (S)
// absorbs the one extra entry that arrives while back-pressure propagates.
// The control vector reads as zero whenever the stage has no valid entry,
// so downstream write enables never fire on a bubble. A saturating counter
// records how many entries flushes have killed.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [CTRL_W-1:0] up_ctrl_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [CTRL_W-1:0] dn_ctrl_o,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  drop_count_o
);

  // Encoding equals the number of held entries, so it drives occupancy_o.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  state_t            r_state;
  state_t            w_state_next;
  logic              r_up_ready;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [CTRL_W-1:0] w_m_ctrl_next;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] w_m_data_next;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [CTRL_W-1:0] w_s_ctrl_next;
  logic [DATA_W-1:0] r_s_data;
  logic [DATA_W-1:0] w_s_data_next;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  w_drop_cnt_next;

  logic              w_m_valid;
  logic              w_s_valid;
  logic              w_accept;
  logic              w_deliver;
  logic [1:0]        w_kill;
  logic [CNT_W+1:0]  w_drop_sum;

  assign w_m_valid = (r_state != ST_EMPTY);
  assign w_s_valid = (r_state == ST_FULL);
  // Acceptance uses the registered ready, keeping dn_ready_i off the upstream path.
  assign w_accept  = up_valid_i & r_up_ready;
  assign w_deliver = w_m_valid & dn_ready_i;

  // Entries killed by a flush: undelivered M, any S, and a same-cycle accept.
  assign w_kill     = {1'b0, w_m_valid & ~w_deliver} + {1'b0, w_s_valid} + {1'b0, w_accept};
  assign w_drop_sum = {2'b00, r_drop_cnt} + {{CNT_W{1'b0}}, w_kill};

  // Next-state and storage update; flush overrides the handshake.
  always_comb begin
    w_state_next    = r_state;
    w_m_ctrl_next   = r_m_ctrl;
    w_m_data_next   = r_m_data;
    w_s_ctrl_next   = r_s_ctrl;
    w_s_data_next   = r_s_data;
    w_drop_cnt_next = r_drop_cnt;
    if (flush_i) begin
      w_state_next  = ST_EMPTY;
      w_m_ctrl_next = '0;
      w_s_ctrl_next = '0;
      if (w_drop_sum > CNT_MAX) begin
        w_drop_cnt_next = {CNT_W{1'b1}};
      end else begin
        w_drop_cnt_next = w_drop_sum[CNT_W-1:0];
      end
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next  = ST_ONE;
            w_m_ctrl_next = up_ctrl_i;
            w_m_data_next = up_data_i;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_m_ctrl_next = up_ctrl_i;
            w_m_data_next = up_data_i;
          end else if (w_accept) begin
            w_state_next  = ST_FULL;
            w_s_ctrl_next = up_ctrl_i;
            w_s_data_next = up_data_i;
          end else if (w_deliver) begin
            w_state_next  = ST_EMPTY;
            w_m_ctrl_next = '0;
          end
        end
        ST_FULL: begin
          if (w_deliver) begin
            w_state_next  = ST_ONE;
            w_m_ctrl_next = r_s_ctrl;
            w_m_data_next = r_s_data;
            w_s_ctrl_next = '0;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // State and storage registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= ST_EMPTY;
      r_up_ready <= 1'b1;
      r_m_ctrl   <= '0;
      r_m_data   <= '0;
      r_s_ctrl   <= '0;
      r_s_data   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_up_ready <= (w_state_next != ST_FULL);
      r_m_ctrl   <= w_m_ctrl_next;
      r_m_data   <= w_m_data_next;
      r_s_ctrl   <= w_s_ctrl_next;
      r_s_data   <= w_s_data_next;
      r_drop_cnt <= w_drop_cnt_next;
    end
  end

  // Control bits are gated by M's valid so a bubble always reads as zero.
  for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
    assign dn_ctrl_o[gi] = r_m_ctrl[gi] & w_m_valid;
  end

  assign up_ready_o   = r_up_ready;
  assign dn_valid_o   = w_m_valid;
  assign dn_data_o    = r_m_data;
  assign occupancy_o  = r_state;
  assign drop_count_o = r_drop_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: table-driven vectors for streaming, stall,
// bubble and flush behaviour, plus hand-written sequences for counter
// saturation (second instance with a 2-bit counter) and asynchronous reset.
module tb_pipe_stage_reg;

  logic         clk_i = 1'b0;
  logic         reset_ni = 1'b1;
  logic         flush_i = 1'b0;
  logic         up_valid_i = 1'b0;
  logic [7:0]   up_ctrl_i = '0;
  logic [132:0] up_data_i = '0;
  logic         dn_ready_i = 1'b0;

  logic         up_ready_o;
  logic         dn_valid_o;
  logic [7:0]   dn_ctrl_o;
  logic [132:0] dn_data_o;
  logic [1:0]   occupancy_o;
  logic [7:0]   drop_count_o;

  logic         u2_up_ready;
  logic         u2_dn_valid;
  logic [7:0]   u2_dn_ctrl;
  logic [132:0] u2_dn_data;
  logic [1:0]   u2_occ;
  logic [1:0]   u2_drop;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(133), .CNT_W(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
    .up_ctrl_i(up_ctrl_i), .up_data_i(up_data_i),
    .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
    .dn_ctrl_o(dn_ctrl_o), .dn_data_o(dn_data_o),
    .occupancy_o(occupancy_o), .drop_count_o(drop_count_o)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(133), .CNT_W(2)) dut2 (
    .clk_i(clk_i), .reset_ni(reset_ni), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_ready_o(u2_up_ready),
    .up_ctrl_i(up_ctrl_i), .up_data_i(up_data_i),
    .dn_valid_o(u2_dn_valid), .dn_ready_i(dn_ready_i),
    .dn_ctrl_o(u2_dn_ctrl), .dn_data_o(u2_dn_data),
    .occupancy_o(u2_occ), .drop_count_o(u2_drop)
  );

  typedef struct {
    logic        flush;
    logic        up_valid;
    logic [7:0]  up_ctrl;
    logic [15:0] up_data;
    logic        dn_ready;
    logic        e_valid;
    logic [7:0]  e_ctrl;
    logic [15:0] e_data;
    logic [1:0]  e_occ;
    logic        e_ready;
    logic [7:0]  e_drop;
    logic [1:0]  e_drop2;
  } vec_t;

  vec_t vecs[$];

  // Spread a 16-bit tag over the full 133-bit data vector.
  function automatic logic [132:0] xd(input logic [15:0] d);
    return {d[4:0], {8{d}}};
  endfunction

  function automatic vec_t mk(input logic fl, input logic uv, input logic [7:0] uc,
                              input logic [15:0] ud, input logic dr, input logic ev,
                              input logic [7:0] ec, input logic [15:0] ed,
                              input logic [1:0] eo, input logic er,
                              input logic [7:0] edr, input logic [1:0] edr2);
    vec_t v;
    v.flush = fl; v.up_valid = uv; v.up_ctrl = uc; v.up_data = ud; v.dn_ready = dr;
    v.e_valid = ev; v.e_ctrl = ec; v.e_data = ed; v.e_occ = eo; v.e_ready = er;
    v.e_drop = edr; v.e_drop2 = edr2;
    return v;
  endfunction

  task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_ni   = 1'b0;
    flush_i    = 1'b0;
    up_valid_i = 1'b0;
    dn_ready_i = 1'b0;
    #2;
    check("rst_dn_valid", {132'd0, dn_valid_o}, 133'd0);
    check("rst_up_ready", {132'd0, up_ready_o}, 133'd1);
    check("rst_occ", {131'd0, occupancy_o}, 133'd0);
    check("rst_drop", {125'd0, drop_count_o}, 133'd0);
    check("rst_dn_data", dn_data_o, 133'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_up_ready", {132'd0, up_ready_o}, 133'd1);
    check("post_rst_dn_valid", {132'd0, dn_valid_o}, 133'd0);
  endtask

  task automatic drive(input logic fl, input logic uv, input logic [7:0] uc,
                       input logic [15:0] ud, input logic dr);
    flush_i = fl; up_valid_i = uv; up_ctrl_i = uc; up_data_i = xd(ud); dn_ready_i = dr;
  endtask

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};

    // Streaming 1..10 at full throughput.
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(0, 1, 8'h11, 16'(k), 1, 1, 8'h11, 16'(k), 1, 1, 0, 0));
    // Stall for three cycles mid-stream with ctrl A5.
    vecs.push_back(mk(0, 1, 8'hA5, 16'd11, 1, 1, 8'hA5, 16'd11, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 16'd12, 0, 1, 8'hA5, 16'd11, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 16'd13, 0, 1, 8'hA5, 16'd11, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 16'd13, 0, 1, 8'hA5, 16'd11, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 16'd13, 1, 1, 8'hA5, 16'd12, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 16'd13, 1, 1, 8'hA5, 16'd13, 1, 1, 0, 0));
    // Bubbles with ctrl FF on the input: ctrl out zero, data held.
    vecs.push_back(mk(0, 0, 8'hFF, 16'd99, 1, 0, 8'h00, 16'd13, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'hFF, 16'd99, 1, 0, 8'h00, 16'd13, 0, 1, 0, 0));
    // Fill to FULL, flush with dn_ready low and input valid: +2.
    vecs.push_back(mk(0, 1, 8'h3C, 16'd20, 0, 1, 8'h3C, 16'd20, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h3C, 16'd21, 0, 1, 8'h3C, 16'd20, 2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h3C, 16'd22, 0, 0, 8'h00, 16'd20, 0, 1, 2, 2));
    vecs.push_back(mk(0, 0, 8'h3C, 16'd22, 1, 0, 8'h00, 16'd20, 0, 1, 2, 2));
    // Flush in FULL while delivering: +1.
    vecs.push_back(mk(0, 1, 8'h01, 16'd30, 0, 1, 8'h01, 16'd30, 1, 1, 2, 2));
    vecs.push_back(mk(0, 1, 8'h01, 16'd31, 0, 1, 8'h01, 16'd30, 2, 0, 2, 2));
    vecs.push_back(mk(1, 1, 8'h01, 16'd32, 1, 0, 8'h00, 16'd30, 0, 1, 3, 3));
    // Flush in ONE with a same-cycle accept: +2 (2-bit counter stays at 3).
    vecs.push_back(mk(0, 1, 8'h02, 16'd40, 0, 1, 8'h02, 16'd40, 1, 1, 3, 3));
    vecs.push_back(mk(1, 1, 8'h02, 16'd41, 0, 0, 8'h00, 16'd40, 0, 1, 5, 3));
    // Flush while empty with an accept: +1.
    vecs.push_back(mk(1, 1, 8'h02, 16'd50, 0, 0, 8'h00, 16'd40, 0, 1, 6, 3));
    // Accept then flush while delivering: no drop.
    vecs.push_back(mk(0, 1, 8'h77, 16'd60, 1, 1, 8'h77, 16'd60, 1, 1, 6, 3));
    vecs.push_back(mk(1, 0, 8'h77, 16'd61, 1, 0, 8'h00, 16'd60, 0, 1, 6, 3));

    #1;
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].up_valid, vecs[i].up_ctrl, vecs[i].up_data, vecs[i].dn_ready);
      @(posedge clk_i);
      #1;
      $display("vec %0d: flush=%0b uv=%0b dr=%0b -> dv=%0b ctrl=%0h data=%0h occ=%0d rdy=%0b drop=%0d/%0d",
               i, vecs[i].flush, vecs[i].up_valid, vecs[i].dn_ready, dn_valid_o, dn_ctrl_o,
               dn_data_o[15:0], occupancy_o, up_ready_o, drop_count_o, u2_drop);
      check($sformatf("v%0d_dn_valid", i), {132'd0, dn_valid_o}, {132'd0, vecs[i].e_valid});
      check($sformatf("v%0d_dn_ctrl", i), {125'd0, dn_ctrl_o}, {125'd0, vecs[i].e_ctrl});
      check($sformatf("v%0d_dn_data", i), dn_data_o, xd(vecs[i].e_data));
      check($sformatf("v%0d_occ", i), {131'd0, occupancy_o}, {131'd0, vecs[i].e_occ});
      check($sformatf("v%0d_up_ready", i), {132'd0, up_ready_o}, {132'd0, vecs[i].e_ready});
      check($sformatf("v%0d_drop", i), {125'd0, drop_count_o}, {125'd0, vecs[i].e_drop});
      check($sformatf("v%0d_drop2", i), {131'd0, u2_drop}, {131'd0, vecs[i].e_drop2});
    end

    // Saturation: five flushes, each killing exactly one entry.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h05, 16'(100 + i), 0);
      @(posedge clk_i);
      #1;
      drive(1, 0, 8'h05, 16'd0, 0);
      @(posedge clk_i);
      #1;
      drive(0, 0, 8'h05, 16'd0, 0);
      $display("sat flush %0d: drop=%0d drop2=%0d occ=%0d", i + 1, drop_count_o, u2_drop, occupancy_o);
      check($sformatf("sat%0d_drop2", i), {131'd0, u2_drop}, 133'(sat_exp[i]));
      check($sformatf("sat%0d_drop", i), {125'd0, drop_count_o}, 133'(i + 1));
      check($sformatf("sat%0d_occ", i), {131'd0, occupancy_o}, 133'd0);
    end

    // Asynchronous reset between edges while FULL.
    drive(0, 1, 8'h09, 16'd70, 0);
    @(posedge clk_i);
    #1;
    drive(0, 1, 8'h09, 16'd71, 0);
    @(posedge clk_i);
    #1;
    check("async_pre_occ", {131'd0, occupancy_o}, 133'd2);
    check("async_pre_ready", {132'd0, up_ready_o}, 133'd0);
    drive(0, 0, 8'h09, 16'd0, 0);
    #2;
    reset_ni = 1'b0;
    #1;
    $display("async reset: dv=%0b rdy=%0b occ=%0d drop=%0d", dn_valid_o, up_ready_o, occupancy_o, drop_count_o);
    check("async_dn_valid", {132'd0, dn_valid_o}, 133'd0);
    check("async_up_ready", {132'd0, up_ready_o}, 133'd1);
    check("async_occ", {131'd0, occupancy_o}, 133'd0);
    check("async_drop", {125'd0, drop_count_o}, 133'd0);
    check("async_dn_ctrl", {125'd0, dn_ctrl_o}, 133'd0);
    check("async_dn_data", dn_data_o, 133'd0);
    #3;
    reset_ni = 1'b1;
    drive(0, 1, 8'h44, 16'd80, 1);
    @(posedge clk_i);
    #1;
    drive(0, 0, 8'h44, 16'd0, 1);
    $display("post reset accept: dv=%0b ctrl=%0h data=%0h", dn_valid_o, dn_ctrl_o, dn_data_o[15:0]);
    check("post_async_dn_valid", {132'd0, dn_valid_o}, 133'd1);
    check("post_async_dn_data", dn_data_o, xd(16'd80));
    check("post_async_dn_ctrl", {125'd0, dn_ctrl_o}, 133'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
